// File: rtl/pe_seq_pkg.sv
// Shared constants for the PE layer sequencer: default widths, WAIT_PE timeout, FSM encodings.
package pe_seq_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 10;
  localparam int PE_TIMEOUT = 4096;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_STREAM  = 3'd2;
  localparam logic [2:0] S_WAIT_PE = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

endpackage

// File: rtl/pe_seq_addr_gen.sv
// Pair index, neuron index and weight base address for the layer walk.
// The weight base advances by NUM_INPUTS per neuron, which avoids a multiplier.
module pe_seq_addr_gen
  import pe_seq_pkg::*;
#(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 10,
  parameter int W_AW        = $clog2(NUM_INPUTS * NUM_NEURONS),
  parameter int X_AW        = $clog2(NUM_INPUTS),
  parameter int N_AW        = $clog2(NUM_NEURONS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            step_i,
  input  logic            next_i,
  output logic [X_AW-1:0] idx_o,
  output logic [N_AW-1:0] neuron_o,
  output logic [W_AW-1:0] w_base_o,
  output logic            last_pair_o,
  output logic            last_neuron_o
);

  logic [X_AW-1:0] idx_q, idx_d;
  logic [N_AW-1:0] neuron_q, neuron_d;
  logic [W_AW-1:0] w_base_q, w_base_d;

  assign last_pair_o   = (idx_q == X_AW'(NUM_INPUTS - 1));
  assign last_neuron_o = (neuron_q == N_AW'(NUM_NEURONS - 1));

  always_comb begin
    idx_d    = idx_q;
    neuron_d = neuron_q;
    w_base_d = w_base_q;
    if (clr_i) begin
      idx_d    = '0;
      neuron_d = '0;
      w_base_d = '0;
    end else if (next_i) begin
      idx_d    = '0;
      neuron_d = neuron_q + N_AW'(1);
      w_base_d = w_base_q + W_AW'(NUM_INPUTS);
    end else if (step_i && !last_pair_o) begin
      idx_d = idx_q + X_AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q    <= '0;
      neuron_q <= '0;
      w_base_q <= '0;
    end else begin
      idx_q    <= idx_d;
      neuron_q <= neuron_d;
      w_base_q <= w_base_d;
    end
  end

  assign idx_o    = idx_q;
  assign neuron_o = neuron_q;
  assign w_base_o = w_base_q;

endmodule

// File: rtl/pe_layer_sequencer.sv
// Walks one PE through a fully connected layer: streams bias + weight/activation pairs per neuron,
// waits for the PE result and hands it out over valid/ready; aborts with a sticky err on timeout.
module pe_layer_sequencer
  import pe_seq_pkg::*;
#(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 10,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = PE_TIMEOUT,
  parameter int W_AW        = $clog2(NUM_INPUTS * NUM_NEURONS),
  parameter int X_AW        = $clog2(NUM_INPUTS),
  parameter int N_AW        = $clog2(NUM_NEURONS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              layer_done,
  output logic              err,
  output logic              w_rd_en,
  output logic [W_AW-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              x_rd_en,
  output logic [X_AW-1:0]   x_addr,
  input  logic [DATA_W-1:0] x_data,
  output logic [N_AW-1:0]   b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic [DATA_W-1:0] pe_w,
  output logic [DATA_W-1:0] pe_x,
  output logic [DATA_W-1:0] pe_b,
  output logic [CNT_W-1:0]  pe_count,
  output logic              pe_head,
  input  logic [DATA_W-1:0] pe_out,
  input  logic              pe_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N_AW-1:0]   res_index,
  output logic [DATA_W-1:0] res_data
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [2:0]        state_q, state_d;
  logic              err_q, err_d;
  logic              res_valid_q, res_valid_d;
  logic [N_AW-1:0]   res_index_q, res_index_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              iss_done_q, rd_vld_q, head_d1_q, last_d1_q, pe_head_q, pe_last_q;
  logic [DATA_W-1:0] pe_w_q, pe_x_q, pe_b_q;

  logic [X_AW-1:0]   idx;
  logic [N_AW-1:0]   neuron;
  logic [W_AW-1:0]   w_base;
  logic              last_pair, last_neuron;
  logic              start_ok, rd_en, capture, handshake, next_neuron;

  assign start_ok    = start && (state_q == S_IDLE);
  assign rd_en       = (state_q == S_ISSUE) || ((state_q == S_STREAM) && !iss_done_q);
  // Capture is gated by state so an abort flushes any read still in flight.
  assign capture     = rd_vld_q && (state_q == S_STREAM);
  assign handshake   = (state_q == S_EMIT) && res_valid_q && res_ready;
  assign next_neuron = handshake && !last_neuron;

  pe_seq_addr_gen #(
    .NUM_INPUTS (NUM_INPUTS),
    .NUM_NEURONS(NUM_NEURONS),
    .W_AW       (W_AW),
    .X_AW       (X_AW),
    .N_AW       (N_AW)
  ) u_addr_gen (
    .clock        (clock),
    .reset        (reset),
    .clr_i        (start_ok),
    .step_i       (rd_en),
    .next_i       (next_neuron),
    .idx_o        (idx),
    .neuron_o     (neuron),
    .w_base_o     (w_base),
    .last_pair_o  (last_pair),
    .last_neuron_o(last_neuron)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    res_valid_d = res_valid_q;
    res_index_d = res_index_q;
    res_data_d  = res_data_q;
    wait_cnt_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          err_d   = 1'b0;
        end
      end
      S_ISSUE: state_d = S_STREAM;
      S_STREAM: begin
        if (pe_done) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (pe_last_q) begin
          state_d = S_WAIT_PE;
        end
      end
      S_WAIT_PE: begin
        if (pe_done) begin
          res_valid_d = 1'b1;
          res_index_d = neuron;
          res_data_d  = pe_out;
          state_d     = S_EMIT;
        end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
          err_d       = 1'b1;
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      S_EMIT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = last_neuron ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_index_q <= '0;
      res_data_q  <= '0;
      wait_cnt_q  <= '0;
      iss_done_q  <= 1'b0;
      rd_vld_q    <= 1'b0;
      head_d1_q   <= 1'b0;
      last_d1_q   <= 1'b0;
      pe_head_q   <= 1'b0;
      pe_last_q   <= 1'b0;
      pe_w_q      <= '0;
      pe_x_q      <= '0;
      pe_b_q      <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_index_q <= res_index_d;
      res_data_q  <= res_data_d;
      wait_cnt_q  <= wait_cnt_d;
      if (start_ok || next_neuron) iss_done_q <= 1'b0;
      else if (rd_en && last_pair)  iss_done_q <= 1'b1;
      rd_vld_q  <= rd_en;
      head_d1_q <= (state_q == S_ISSUE);
      last_d1_q <= rd_en && last_pair;
      pe_head_q <= capture && head_d1_q;
      pe_last_q <= capture && last_d1_q;
      if (capture) begin
        pe_w_q <= w_data;
        pe_x_q <= x_data;
      end
      if (capture && head_d1_q) pe_b_q <= b_data;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign layer_done = (state_q == S_DONE);
  assign err        = err_q;
  assign w_rd_en    = rd_en;
  assign x_rd_en    = rd_en;
  assign w_addr     = rd_en ? (w_base + W_AW'(idx)) : '0;
  assign x_addr     = rd_en ? idx : '0;
  assign b_addr     = busy ? neuron : '0;
  assign pe_w       = pe_w_q;
  assign pe_x       = pe_x_q;
  assign pe_b       = pe_b_q;
  assign pe_count   = busy ? CNT_W'(NUM_INPUTS) : '0;
  assign pe_head    = pe_head_q;
  assign res_valid  = res_valid_q;
  assign res_index  = res_index_q;
  assign res_data   = res_data_q;

endmodule

// File: tb/tb_pe_layer_sequencer.sv
// Directed bench: 4-input, 2-neuron layer with synchronous memories and a behavioural PE
// (b + sum(w*x), done 3 cycles after the last pair).
module tb_pe_layer_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, res_ready;
  logic        busy, layer_done, err, w_rd_en, x_rd_en, pe_head, pe_done, res_valid;
  logic [2:0]  w_addr;
  logic [1:0]  x_addr;
  logic [0:0]  b_addr, res_index;
  logic [31:0] w_data = '0, x_data = '0, b_data = '0, pe_out = '0;
  logic [31:0] pe_w, pe_x, pe_b, res_data;
  logic [9:0]  pe_count;

  logic [31:0] wmem [8];
  logic [31:0] xmem [4];
  logic [31:0] bmem [2];

  logic        pe_done_m = 1'b0;
  logic        pe_en = 1'b1;
  logic        inj = 1'b0;
  int          k = 0;
  int          dly = 0;
  real         acc = 0.0;

  int          n_chk = 0;
  int          n_fail = 0;
  int          ld_cnt = 0;
  logic [0:0]  ridx_q [$];
  logic [31:0] rdat_q [$];
  logic        any_out;

  always #5 clock = ~clock;

  pe_layer_sequencer #(.NUM_INPUTS(4), .NUM_NEURONS(2)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .layer_done(layer_done),
    .err(err), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data), .x_rd_en(x_rd_en),
    .x_addr(x_addr), .x_data(x_data), .b_addr(b_addr), .b_data(b_data), .pe_w(pe_w),
    .pe_x(pe_x), .pe_b(pe_b), .pe_count(pe_count), .pe_head(pe_head), .pe_out(pe_out),
    .pe_done(pe_done), .res_valid(res_valid), .res_ready(res_ready),
    .res_index(res_index), .res_data(res_data)
  );

  assign pe_done = pe_done_m | inj;
  assign any_out = busy | layer_done | err | w_rd_en | x_rd_en | (|w_addr) | (|x_addr) |
                   (|b_addr) | (|pe_w) | (|pe_x) | (|pe_b) | (|pe_count) | pe_head |
                   res_valid | (|res_index) | (|res_data);

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic        s;
    int          e;
    real         a;
    logic [22:0] m;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = 23'($rtoi((a - 1.0) * 8388608.0));
    return {s, 8'(e + 127), m};
  endfunction

  always @(posedge clock) begin
    if (w_rd_en) begin
      w_data <= wmem[w_addr];
      b_data <= bmem[b_addr];
    end
    if (x_rd_en) x_data <= xmem[x_addr];
  end

  always @(posedge clock) begin
    if (reset) begin
      k = 0;
      dly = 0;
      pe_done_m <= 1'b0;
    end else begin
      pe_done_m <= 1'b0;
      if (dly == 1) begin
        if (pe_en) begin
          pe_done_m <= 1'b1;
          pe_out    <= r2f(acc);
        end
        dly = 0;
      end else if (dly > 1) begin
        dly--;
      end
      if (pe_head) begin
        acc = f2r(pe_b) + f2r(pe_w) * f2r(pe_x);
        k = 1;
      end else if (k > 0 && k < 4) begin
        acc = acc + f2r(pe_w) * f2r(pe_x);
        k++;
      end
      if (k == 4) begin
        dly = 2;
        k = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (res_valid && res_ready) begin
      ridx_q.push_back(res_index);
      rdat_q.push_back(res_data);
    end
    if (layer_done) ld_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_layer(input string tag, input int base);
    int n = 0;
    while (ld_cnt == base && n < 400) begin step(); n++; end
    step();
    step();
    chk(tag, 64'(ld_cnt - base), 64'd1);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic chk_res(input string tag, input int pos, input logic [0:0] idx,
                         input logic [31:0] dat);
    if (pos < rdat_q.size()) begin
      chk({tag, "_idx"}, ridx_q[pos], idx);
      chk({tag, "_dat"}, rdat_q[pos], dat);
    end else begin
      chk({tag, "_missing"}, 64'(rdat_q.size()), 64'(pos + 1));
    end
  endtask

  task automatic load_distinct();
    wmem = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    xmem = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000};
    bmem = '{32'h3F000000, 32'hBF800000};
  endtask

  initial begin
    int n, rb, lb, hs, bad, rd;
    logic [0:0]  i0;
    logic [31:0] d0;
    reset = 1'b1; start = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < 8; i++) wmem[i] = 32'h3F800000;
    for (int i = 0; i < 4; i++) xmem[i] = 32'h40000000;
    bmem = '{32'h0, 32'h0};
    step(); step();
    chk("rst_outs_zero", any_out, 1'b0);
    chk("rst_pe_count", pe_count, 10'd0);
    reset = 1'b0;
    step();

    // 1: uniform data, latency and layer completion
    rb = rdat_q.size(); lb = ld_cnt;
    run_start();
    chk("t1_busy", busy, 1'b1);
    chk("t1_issue_rd", {w_rd_en, x_rd_en, w_addr, b_addr}, {1'b1, 1'b1, 3'd0, 1'b0});
    n = 0;
    while (!res_valid && n < 50) begin step(); n++; end
    chk("t1_latency", n, 9);
    wait_layer("t1_layer_done", lb);
    chk("t1_nres", 64'(rdat_q.size() - rb), 64'd2);
    chk_res("t1_r0", rb, 1'b0, 32'h41000000);
    chk_res("t1_r1", rb + 1, 1'b1, 32'h41000000);

    // 2: head alignment and gap-free pairs
    load_distinct();
    rb = rdat_q.size(); lb = ld_cnt;
    run_start();
    for (int nn = 0; nn < 2; nn++) begin
      n = 0;
      while (!pe_head && n < 40) begin step(); n++; end
      if (nn == 0) chk("t2_head_lat", n, 2);
      chk($sformatf("t2_head_n%0d", nn), pe_head, 1'b1);
      chk($sformatf("t2_b_n%0d", nn), pe_b, bmem[nn]);
      chk($sformatf("t2_cnt_n%0d", nn), pe_count, 10'd4);
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("t2_w_n%0d_%0d", nn, j), pe_w, wmem[nn * 4 + j]);
        chk($sformatf("t2_x_n%0d_%0d", nn, j), pe_x, xmem[j]);
        chk($sformatf("t2_hd_n%0d_%0d", nn, j), pe_head, (j == 0));
        step();
      end
    end
    wait_layer("t2_layer_done", lb);
    chk_res("t2_r0", rb, 1'b0, 32'h41840000);
    chk_res("t2_r1", rb + 1, 1'b1, 32'h421C0000);

    // 3: backpressure in EMIT
    res_ready = 1'b0;
    rb = rdat_q.size(); lb = ld_cnt;
    run_start();
    n = 0;
    while (!res_valid && n < 50) begin step(); n++; end
    chk("t3_valid_seen", res_valid, 1'b1);
    i0 = res_index; d0 = res_data;
    bad = 0; rd = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (res_valid !== 1'b1 || res_index !== i0 || res_data !== d0) bad++;
      if (w_rd_en) rd++;
    end
    chk("t3_stable", bad, 0);
    chk("t3_no_next", rd, 0);
    chk("t3_hold_idx", res_index, 1'b0);
    chk("t3_hold_dat", res_data, 32'h41840000);
    res_ready = 1'b1;
    step();
    chk("t3_valid_drop", res_valid, 1'b0);
    chk("t3_next_issue", {w_rd_en, w_addr, b_addr}, {1'b1, 3'd4, 1'b1});
    wait_layer("t3_layer_done", lb);
    chk_res("t3_r0", rb, 1'b0, 32'h41840000);
    chk_res("t3_r1", rb + 1, 1'b1, 32'h421C0000);

    // 4: PE never completes
    pe_en = 1'b0;
    rb = rdat_q.size(); lb = ld_cnt;
    run_start();
    n = 0;
    while (!err && n < 5000) begin step(); n++; end
    chk("t4_err_lat", n, 4102);
    chk("t4_idle", busy, 1'b0);
    chk("t4_no_valid", res_valid, 1'b0);
    repeat (5) step();
    chk("t4_err_sticky", err, 1'b1);
    chk("t4_no_done", 64'(ld_cnt - lb), 64'd0);
    pe_en = 1'b1;
    run_start();
    chk("t4_err_clr", err, 1'b0);
    wait_layer("t4_layer_done", lb);
    chk("t4_nres", 64'(rdat_q.size() - rb), 64'd2);
    chk_res("t4_r1", rb + 1, 1'b1, 32'h421C0000);

    // 5: reset during STREAM of neuron 1
    rb = rdat_q.size(); lb = ld_cnt;
    run_start();
    n = 0; hs = 0;
    while (n < 60) begin
      step(); n++;
      if (pe_head) begin
        hs++;
        if (hs == 2) break;
      end
    end
    chk("t5_head2", hs, 2);
    reset = 1'b1;
    step();
    chk("t5_rst_outs_zero", any_out, 1'b0);
    reset = 1'b0;
    repeat (3) step();
    chk("t5_no_done", 64'(ld_cnt - lb), 64'd0);
    chk("t5_partial_nres", 64'(rdat_q.size() - rb), 64'd1);
    rb = rdat_q.size(); lb = ld_cnt;
    run_start();
    wait_layer("t5_layer_done", lb);
    chk_res("t5_r0", rb, 1'b0, 32'h41840000);
    chk_res("t5_r1", rb + 1, 1'b1, 32'h421C0000);

    // 6: start while busy is ignored; pe_done during STREAM aborts
    rb = rdat_q.size(); lb = ld_cnt;
    run_start();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_busy", busy, 1'b1);
    chk("t6_addr_cont", {w_rd_en, w_addr}, {1'b1, 3'd2});
    inj = 1'b1;
    step();
    inj = 1'b0;
    chk("t6_err", err, 1'b1);
    chk("t6_idle", busy, 1'b0);
    repeat (20) step();
    chk("t6_no_done", 64'(ld_cnt - lb), 64'd0);
    chk("t6_no_res", 64'(rdat_q.size() - rb), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_layer_sequencer.md
Name: pe_layer_sequencer

Overview:
Controller that sequences one proElement instance through a fully connected layer, neuron by neuron. For each neuron it reads a bias and NUM_INPUTS weight/activation pairs from synchronous-read memories, streams them to the PE with a one-cycle head pulse, then waits for done_flag and emits pe_out through a valid/ready result port. It sits between the layer memories and the PE, and is started once per layer by the top-level network controller.

Parameters:
NUM_INPUTS, 784, activations per neuron (1..1023; fits the 10-bit PE count)
NUM_NEURONS, 10, neurons in the layer
DATA_W, 32, IEEE-754 single word width
CNT_W, 10, width of the PE count port
TIMEOUT, 4096, max cycles in WAIT_PE before abort
W_AW, $clog2(NUM_INPUTS*NUM_NEURONS), weight address width
X_AW, $clog2(NUM_INPUTS), activation address width
N_AW, $clog2(NUM_NEURONS), neuron index / bias address width

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begin layer (ignored unless IDLE)
busy  out  1  high from the cycle after an accepted start until return to IDLE
layer_done  out  1  one-cycle pulse after the last result handshake
err  out  1  sticky timeout/protocol error; cleared by start or reset
w_rd_en  out  1  weight memory read enable
w_addr  out  W_AW  weight address = neuron*NUM_INPUTS + i
w_data  in  DATA_W  weight read data, valid 1 cycle after w_rd_en
x_rd_en  out  1  activation memory read enable
x_addr  out  X_AW  activation address = i
x_data  in  DATA_W  activation read data, 1-cycle latency
b_addr  out  N_AW  bias address = neuron (read together with index 0)
b_data  in  DATA_W  bias read data, 1-cycle latency
pe_w, pe_x, pe_b  out  DATA_W  PE operands, registered
pe_count  out  CNT_W  NUM_INPUTS, held constant while busy
pe_head  out  1  one-cycle start-of-neuron marker, aligned with pair 0
pe_out  in  DATA_W  PE result
pe_done  in  1  PE done_flag; pe_out valid in the same cycle
res_valid  out  1  result valid
res_ready  in  1  downstream ready
res_index  out  N_AW  neuron index of the result
res_data  out  DATA_W  captured pe_out

Behaviour:
- Reset: state IDLE; all outputs 0, except pe_count, which is 0 in IDLE. err is cleared.
- States: IDLE, ISSUE, STREAM, WAIT_PE, EMIT, DONE.
- IDLE: on start, go to ISSUE and clear neuron to 0 and err to 0.
- ISSUE (1 cycle): assert w_rd_en/x_rd_en for i=0, drive b_addr=neuron, then go to STREAM.
- STREAM: each cycle, issue read i+1 while the data for i arrives from memory.
- pe_w/pe_x/pe_b are registered from memory data, so each pair reaches the PE 2 cycles after its address is issued.
- pe_head=1 exactly in the cycle pair 0 is presented; pe_b is valid in that cycle and held until the next neuron.
- Exactly NUM_INPUTS consecutive pairs, with no bubbles. Read enables drop after i=NUM_INPUTS-1 is issued.
- After the last pair has been presented, go to WAIT_PE. pe_w/pe_x hold their last values.
- WAIT_PE: on pe_done, capture pe_out into res_data, set res_index=neuron and res_valid=1, and go to EMIT.
- WAIT_PE timeout: a cycle counter reaching TIMEOUT sets err, drops res_valid, and goes to IDLE with no layer_done.
- pe_done during STREAM is a protocol error: set err and abort to IDLE.
- EMIT: hold res_valid/res_index/res_data stable until res_valid&&res_ready.
  - On handshake: if neuron==NUM_NEURONS-1, go to DONE; else increment neuron and go to ISSUE.
  - res_valid drops the cycle after the handshake, unless the next result is already ready, which is not possible because ISSUE intervenes.
- DONE: pulse layer_done for 1 cycle, then go to IDLE.
- start in any state other than IDLE is ignored.
- Reset asserted mid-operation returns to IDLE next edge. Any partial neuron is discarded, and no res_valid or layer_done is emitted.
- Minimum per-neuron latency, from ISSUE to res_valid: NUM_INPUTS + 2 + PE latency cycles.
- Address arithmetic: the w_addr base increments by NUM_INPUTS per neuron (adder, no multiplier). x_addr wraps to 0 per neuron.
- No floating-point arithmetic in this block.

Decomposition:
- Shared package pe_seq_pkg: state enum, default DATA_W/CNT_W, and the TIMEOUT constant.
- One natural sub-module: pe_seq_addr_gen, which generates i, neuron, and w_base and provides last-pair/last-neuron flags.
- The FSM and the operand/result registers stay in the top module.

Test Plan:
Bench setup: NUM_INPUTS=4, NUM_NEURONS=2, behavioural PE model computing b+sum(w*x) with done 3 cycles after the last pair.
1. Weights all 1.0 (3F800000), activations 2.0 (40000000), bias 0 -> res 0: 41000000 (8.0); res 1: same; then one layer_done pulse.
2. Head alignment: check pe_head high exactly once per neuron, coincident with pair 0, and pe_count=4 -> head is in the same cycle as w[0]/x[0]; 4 consecutive pairs with no gaps.
3. Backpressure: hold res_ready=0 for 10 cycles in EMIT -> res_valid, res_index, and res_data stay stable; the next neuron does not start until the handshake.
4. PE never asserts done -> err=1 after TIMEOUT cycles, FSM in IDLE, no layer_done; a new start clears err.
5. Reset pulsed during STREAM of neuron 1 -> next cycle all outputs 0. A subsequent start produces full correct results for both neurons.
6. start pulsed while busy, and pe_done injected during STREAM -> the extra start is ignored; the injected pe_done sets err and aborts to IDLE.
